// File: rtl/branch_pc_unit.sv
// branch_pc_unit: execute-stage branch resolution, fetch PC register,
// flush request, misaligned-target trap and branch statistics counters.
module branch_pc_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [XLEN-1:0] TRAP_VEC = 64'h100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            valid_ex,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic [5:0]      flags,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            taken,
  output logic            flush,
  output logic            trap,
  output logic [31:0]     branch_count,
  output logic [31:0]     taken_count
);

  logic [XLEN-1:0] pc_q, pc_d, target;
  logic            trap_q, trap_d;
  logic [31:0]     bcnt_q, bcnt_d, tcnt_q, tcnt_d;
  logic            cond_sel, cond, go, misaligned, br_only;
  logic            unused_alu_lsb;

  // JALR clears bit 0 of the ALU sum, so that bit never reaches the target.
  assign unused_alu_lsb = alu_result[0];

  // Pick the ALU flag named by funct3; the two reserved encodings never branch.
  always_comb begin
    cond_sel = 1'b0;
    case (funct3)
      3'b000:  cond_sel = flags[0];
      3'b001:  cond_sel = flags[1];
      3'b100:  cond_sel = flags[2];
      3'b101:  cond_sel = flags[3];
      3'b110:  cond_sel = flags[4];
      3'b111:  cond_sel = flags[5];
      default: cond_sel = 1'b0;
    endcase
  end

  // Redirect decision; jalr outranks jal, which outranks a conditional branch.
  always_comb begin
    target     = jalr ? {alu_result[XLEN-1:1], 1'b0} : ex_pc + imm;
    cond       = jalr | jal | (branch & cond_sel);
    go         = valid_ex & ~stall & cond;
    misaligned = go & (target[1:0] != 2'b00);
    br_only    = valid_ex & ~stall & branch & ~jal & ~jalr;
  end

  assign taken     = go & ~misaligned;
  assign flush     = go;
  assign link_addr = ex_pc + XLEN'(4);

  // Next-state for PC, trap pulse and counters; stall freezes everything but trap.
  always_comb begin
    pc_d   = pc_q;
    trap_d = misaligned;
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (!stall) begin
      if (misaligned)  pc_d = TRAP_VEC;
      else if (taken)  pc_d = target;
      else             pc_d = pc_q + XLEN'(4);
      // A trapping branch is not counted as resolved.
      if (br_only && !misaligned) bcnt_d = bcnt_q + 32'd1;
      if (taken)                  tcnt_d = tcnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset taking priority over any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      trap_q <= 1'b0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      trap_q <= trap_d;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign pc           = pc_q;
  assign trap         = trap_q;
  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a reference model pushes the expected
// post-edge state to a scoreboard queue, popped and compared after each edge.
module tb_branch_pc_unit;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [63:0] TVEC   = 64'h100;

  logic        clk = 1'b0;
  logic        rst, stall, valid_ex, branch, jal, jalr;
  logic [2:0]  funct3;
  logic [5:0]  flags;
  logic [63:0] alu_result, ex_pc, imm, pc, link_addr;
  logic        taken, flush, trap;
  logic [31:0] branch_count, taken_count;

  always #5 clk = ~clk;

  branch_pc_unit #(.XLEN(64), .RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_ex(valid_ex), .branch(branch),
    .jal(jal), .jalr(jalr), .funct3(funct3), .flags(flags),
    .alu_result(alu_result), .ex_pc(ex_pc), .imm(imm), .pc(pc),
    .link_addr(link_addr), .taken(taken), .flush(flush), .trap(trap),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        trap;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] m_pc;
  logic        m_trap;
  logic [31:0] m_bc, m_tc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: drive, check combinational outputs, model the edge,
  // queue the expected state, then pop and compare after the edge.
  task automatic step(string tag, bit r, bit s, bit v, bit b, bit j, bit jr,
                      logic [2:0] f3, logic [5:0] fl,
                      logic [63:0] alu, logic [63:0] epc, logic [63:0] im);
    bit          sel, cnd, g, mis, tk;
    logic [63:0] tgt;
    exp_t        e;
    rst = r; stall = s; valid_ex = v; branch = b; jal = j; jalr = jr;
    funct3 = f3; flags = fl; alu_result = alu; ex_pc = epc; imm = im;
    #1;
    case (f3)
      3'd0: sel = fl[0];
      3'd1: sel = fl[1];
      3'd4: sel = fl[2];
      3'd5: sel = fl[3];
      3'd6: sel = fl[4];
      3'd7: sel = fl[5];
      default: sel = 1'b0;
    endcase
    if (jr) tgt = alu & ~64'h1;
    else    tgt = epc + im;
    cnd = jr | j | (b & sel);
    g   = v & ~s & cnd;
    mis = g & (tgt[1:0] != 2'b00);
    tk  = g & ~mis;
    chk({tag, ".taken"}, {63'b0, taken}, {63'b0, tk});
    chk({tag, ".flush"}, {63'b0, flush}, {63'b0, g});
    chk({tag, ".link"},  link_addr, epc + 64'd4);
    if (r) begin
      m_pc = RST_PC; m_trap = 1'b0; m_bc = '0; m_tc = '0;
    end else begin
      m_trap = mis;
      if (!s) begin
        if (mis)     m_pc = TVEC;
        else if (tk) m_pc = tgt;
        else         m_pc = m_pc + 64'd4;
        if (v && b && !j && !jr && !mis) m_bc = m_bc + 1;
        if (tk) m_tc = m_tc + 1;
      end
    end
    e.tag = tag; e.pc = m_pc; e.trap = m_trap; e.bc = m_bc; e.tc = m_tc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   pc, e.pc);
      chk({e.tag, ".trap"}, {63'b0, trap}, {63'b0, e.trap});
      chk({e.tag, ".bc"},   {32'b0, branch_count}, {32'b0, e.bc});
      chk({e.tag, ".tc"},   {32'b0, taken_count},  {32'b0, e.tc});
    end
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0, 64'd0, 64'h0, 64'd0);
  endtask

  initial begin
    m_pc = '0; m_trap = 1'b0; m_bc = '0; m_tc = '0;
    // Reset for two cycles, then free-running fetch.
    step("rst0", 1, 0, 0, 0, 0, 0, 3'd0, 6'd0, 64'd0, 64'h0, 64'd0);
    step("rst1", 1, 0, 0, 0, 0, 0, 3'd0, 6'd0, 64'd0, 64'h0, 64'd0);
    chk("reset_pc", pc, 64'h0);
    idle("seq4"); idle("seq8"); idle("seq12");
    chk("seq_pc12", pc, 64'd12);

    // BEQ taken.
    step("beq", 0, 0, 1, 1, 0, 0, 3'b000, 6'b101001, 64'd0, 64'h40, 64'h20);
    chk("beq_pc", pc, 64'h60);
    chk("beq_cnt", {branch_count, taken_count}, {32'd1, 32'd1});
    // BLTU not taken and reserved funct3.
    step("bltu_nt", 0, 0, 1, 1, 0, 0, 3'b110, 6'b101001, 64'd0, 64'h60, 64'h80);
    step("f3_010",  0, 0, 1, 1, 0, 0, 3'b010, 6'b111111, 64'd0, 64'h64, 64'h80);
    chk("nt_pc", pc, 64'h68);

    // JALR aligned, misaligned trap, then a bit-0 clear case.
    step("jalr_a",  0, 0, 1, 0, 0, 1, 3'd0, 6'd0, 64'h1235, 64'h68, 64'd0);
    chk("jalr_a_pc", pc, 64'h1234);
    step("jalr_m",  0, 0, 1, 0, 0, 1, 3'd0, 6'd0, 64'h1237, 64'h1234, 64'd0);
    chk("trap_pc", pc, TVEC);
    chk("trap_hi", {63'b0, trap}, 64'd1);
    idle("trap_off");
    step("jalr_b",  0, 0, 1, 0, 0, 1, 3'd0, 6'd0, 64'h1001, 64'h200, 64'd0);
    chk("jalr_b_pc", pc, 64'h1000);
    // Misaligned taken branch: traps, counts nothing.
    step("br_mis",  0, 0, 1, 1, 0, 0, 3'b000, 6'b000001, 64'd0, 64'h40, 64'h2);
    idle("br_mis_off");

    // JAL held under stall for three cycles, then resolves.
    step("stall0", 0, 1, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h10, 64'h100);
    step("stall1", 0, 1, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h10, 64'h100);
    step("stall2", 0, 1, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h10, 64'h100);
    step("unstall", 0, 0, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h10, 64'h100);
    chk("unstall_pc", pc, 64'h110);

    // Invalid EX instruction with kind bits high has no effect.
    step("inval", 0, 0, 0, 1, 1, 1, 3'd0, 6'h3f, 64'h5000, 64'h30, 64'h40);
    // Priority: jalr over jal over branch.
    step("prio", 0, 0, 1, 1, 1, 1, 3'd0, 6'h3f, 64'h2000, 64'h0, 64'h3000);
    chk("prio_pc", pc, 64'h2000);

    // Wrap of fetch PC and of branch target arithmetic.
    step("to_top", 0, 0, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    idle("pc_wrap");
    chk("pc_wrap0", pc, 64'h0);
    step("br_wrap", 0, 0, 1, 1, 0, 0, 3'b000, 6'b000001, 64'd0, 64'h8, -64'sd16);
    chk("br_wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFF8);

    // Back-to-back redirects, then reset during a redirect.
    step("b2b0", 0, 0, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h100, 64'h400);
    step("b2b1", 0, 0, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h500, 64'h80);
    chk("b2b_pc", pc, 64'h580);
    step("rst_mid", 1, 0, 1, 0, 1, 0, 3'd0, 6'd0, 64'd0, 64'h100, 64'h400);
    chk("rst_mid_cnt", {branch_count, taken_count}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
